// File: rtl/key_conditioner.sv
// key_conditioner: turns raw bouncing key pins into a debounced level plus press, release and auto-repeat pulses.
// Each key runs its own synchronizer, debounce counter and repeat FSM; the keys share no state.
module key_conditioner #(
  parameter int N_KEYS          = 7,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] i_raw,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_repeat,
  output logic              o_any_press
);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] RPT   = 2'd2;
  // Synchronizers reset to the released pin level so reset itself never looks like a press.
  localparam logic RELEASED_RAW = ACTIVE_LOW != 0;

  logic [N_KEYS-1:0] press_all;
  logic              any_q;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic          s1_q, s2_q;
    logic          pressed, hit, fire, press_k, rel_k, rep_d;
    logic          stable_q, stable_d;
    logic          press_q, release_q, repeat_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    assign pressed  = ACTIVE_LOW != 0 ? !s2_q : s2_q;
    assign hit      = pressed == stable_q;
    assign fire     = !hit && cnt_q == CNT_LAST;
    assign cnt_d    = (hit || fire) ? '0 : cnt_q + 1'b1;
    assign stable_d = fire ? pressed : stable_q;
    assign press_k  = fire && pressed;
    assign rel_k    = fire && !pressed;
    assign press_all[k] = press_k;

    // Release (or a low level) dominates, so a repeat due on the release edge is dropped.
    always_comb begin
      rep_d   = 1'b0;
      state_d = state_q;
      rcnt_d  = rcnt_q;
      if (press_k) begin
        rep_d   = 1'b1;
        rcnt_d  = '0;
        state_d = REPEAT_DELAY == 0 ? IDLE : DELAY;
      end else if (rel_k || !stable_q || state_q == IDLE) begin
        state_d = IDLE;
        rcnt_d  = '0;
      end else begin
        rep_d   = rcnt_q == (state_q == DELAY ? DELAY_LAST : RATE_LAST);
        rcnt_d  = rep_d ? '0 : rcnt_q + 1'b1;
        state_d = rep_d ? RPT : state_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q      <= RELEASED_RAW;
        s2_q      <= RELEASED_RAW;
        cnt_q     <= '0;
        stable_q  <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        state_q   <= IDLE;
        rcnt_q    <= '0;
      end else begin
        s1_q      <= i_raw[k];
        s2_q      <= s1_q;
        cnt_q     <= cnt_d;
        stable_q  <= stable_d;
        press_q   <= press_k;
        release_q <= rel_k;
        repeat_q  <= rep_d;
        state_q   <= state_d;
        rcnt_q    <= rcnt_d;
      end
    end

    assign o_level[k]   = stable_q;
    assign o_press[k]   = press_q;
    assign o_release[k] = release_q;
    assign o_repeat[k]  = repeat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_q <= 1'b0;
    else        any_q <= |press_all;
  end

  assign o_any_press = any_q;
endmodule
